// File: rtl/ci_stim_pkg.sv
// Shared types and timing defaults for the cochlear-implant stimulator:
// FSM state encoding, switch/enable output vector and its state decoder.
package ci_stim_pkg;

  localparam int DEF_UNIT_CYC      = 10;
  localparam int DEF_GAP_CYC       = 2;
  localparam int DEF_IDLE_UNIT_CYC = 100;

  typedef enum logic [2:0] {
    S_STOP,
    S_ANO,
    S_GAP,
    S_CAT,
    S_IPI
  } stim_state_t;

  typedef struct packed {
    logic ano_top;
    logic ano_bot;
    logic cat_top;
    logic cat_bot;
    logic curr_ena;
  } stim_out_t;

  // Only the two active phases close a current path; every other state opens all switches.
  function automatic stim_out_t decode_outputs(stim_state_t s);
    stim_out_t o;
    o = '0;
    case (s)
      S_ANO: begin
        o.ano_top  = 1'b1;
        o.cat_bot  = 1'b1;
        o.curr_ena = 1'b1;
      end
      S_CAT: begin
        o.cat_top  = 1'b1;
        o.ano_bot  = 1'b1;
        o.curr_ena = 1'b1;
      end
      default: o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/ci_stim_fpga_wrapper_if.sv
// Board-level button/setting inputs and H-bridge/LED outputs of the stimulator.
interface ci_stim_fpga_wrapper_if;
  logic       i_start_btn;
  logic       i_stop_btn;
  logic [2:0] i_duty;
  logic [2:0] i_idle;
  logic       o_ano_top;
  logic       o_ano_bot;
  logic       o_cat_top;
  logic       o_cat_bot;
  logic       o_curr_ena;
  logic       o_led_r;
  logic       o_led_g;
  logic       o_led_b;

  modport master (
    output i_start_btn, i_stop_btn, i_duty, i_idle,
    input  o_ano_top, o_ano_bot, o_cat_top, o_cat_bot, o_curr_ena,
    input  o_led_r, o_led_g, o_led_b
  );

  modport slave (
    input  i_start_btn, i_stop_btn, i_duty, i_idle,
    output o_ano_top, o_ano_bot, o_cat_top, o_cat_bot, o_curr_ena,
    output o_led_r, o_led_g, o_led_b
  );
endinterface

// File: rtl/ci_btn_edge.sv
// Two-flop synchronizer for an asynchronous push-button level followed by a
// registered rising-edge detector producing a one-cycle pulse.
module ci_btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic pulse
);
  logic sync_meta_reg;
  logic sync_q_reg;
  logic sync_prev_reg;
  logic pulse_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_meta_reg <= 1'b0;
      sync_q_reg    <= 1'b0;
      sync_prev_reg <= 1'b0;
      pulse_reg     <= 1'b0;
    end else begin
      sync_meta_reg <= level;
      sync_q_reg    <= sync_meta_reg;
      sync_prev_reg <= sync_q_reg;
      pulse_reg     <= sync_q_reg & ~sync_prev_reg;
    end
  end

  assign pulse = pulse_reg;
endmodule

// File: rtl/ci_stim_fpga_wrapper.sv
// Stimulator top: button conditioning, biphasic pulse FSM with phase/interval
// timers, and glitch-free registered switch, current-enable and LED outputs.
module ci_stim_fpga_wrapper
  import ci_stim_pkg::*;
#(
  parameter int UNIT_CYC      = DEF_UNIT_CYC,
  parameter int GAP_CYC       = DEF_GAP_CYC,
  parameter int IDLE_UNIT_CYC = DEF_IDLE_UNIT_CYC
) (
  input logic                  i_clk,
  input logic                  i_rst,
  ci_stim_fpga_wrapper_if.slave bus
);
  localparam int MAX_UNIT = (UNIT_CYC > IDLE_UNIT_CYC) ? UNIT_CYC : IDLE_UNIT_CYC;
  localparam int CNT_W    = $clog2(8 * MAX_UNIT + 1);

  typedef logic [CNT_W-1:0] cnt_t;

  function automatic cnt_t scaled_len(logic [2:0] code, int unsigned unit);
    return cnt_t'(({1'b0, code} + 4'd1) * unit);
  endfunction

  // Index 0 is start, index 1 is stop.
  logic [1:0] btn_level;
  logic [1:0] btn_pulse;
  logic       start_pulse;
  logic       stop_pulse;

  assign btn_level = {bus.i_stop_btn, bus.i_start_btn};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
      ci_btn_edge u_btn_edge (
        .clk  (i_clk),
        .rst  (i_rst),
        .level(btn_level[gi]),
        .pulse(btn_pulse[gi])
      );
    end
  endgenerate

  assign start_pulse = btn_pulse[0];
  assign stop_pulse  = btn_pulse[1];

  stim_state_t state_reg, state_next;
  cnt_t        cnt_reg, cnt_next;
  logic        stop_req_reg, stop_req_next;
  logic [2:0]  duty_reg, duty_next;
  logic [2:0]  idle_reg, idle_next;
  stim_out_t   out_reg;
  logic        led_r_reg;
  logic        cnt_done;

  assign cnt_done = (cnt_reg == cnt_t'(1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg    <= S_STOP;
      cnt_reg      <= '0;
      stop_req_reg <= 1'b0;
      duty_reg     <= '0;
      idle_reg     <= '0;
      out_reg      <= '0;
      led_r_reg    <= 1'b1;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      stop_req_reg <= stop_req_next;
      duty_reg     <= duty_next;
      idle_reg     <= idle_next;
      out_reg      <= decode_outputs(state_next);
      led_r_reg    <= (state_next == S_STOP);
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    stop_req_next = stop_req_reg;
    duty_next     = duty_reg;
    idle_next     = idle_reg;

    // A stop request never truncates the biphasic pulse; it is honoured in S_IPI.
    if (state_reg != S_STOP && stop_pulse) begin
      stop_req_next = 1'b1;
    end

    case (state_reg)
      S_STOP: begin
        if (start_pulse && !stop_pulse) begin
          state_next = S_ANO;
          cnt_next   = scaled_len(bus.i_duty, UNIT_CYC);
          duty_next  = bus.i_duty;
          idle_next  = bus.i_idle;
        end
      end
      S_ANO: begin
        if (cnt_done) begin
          state_next = S_GAP;
          cnt_next   = cnt_t'(GAP_CYC);
        end else begin
          cnt_next = cnt_reg - cnt_t'(1);
        end
      end
      S_GAP: begin
        if (cnt_done) begin
          state_next = S_CAT;
          cnt_next   = scaled_len(duty_reg, UNIT_CYC);
        end else begin
          cnt_next = cnt_reg - cnt_t'(1);
        end
      end
      S_CAT: begin
        if (cnt_done) begin
          state_next = S_IPI;
          cnt_next   = scaled_len(idle_reg, IDLE_UNIT_CYC);
        end else begin
          cnt_next = cnt_reg - cnt_t'(1);
        end
      end
      S_IPI: begin
        if (stop_req_reg || stop_pulse) begin
          state_next    = S_STOP;
          cnt_next      = '0;
          stop_req_next = 1'b0;
        end else if (cnt_done) begin
          // Settings are sampled once per pulse so both phases stay matched.
          state_next = S_ANO;
          cnt_next   = scaled_len(bus.i_duty, UNIT_CYC);
          duty_next  = bus.i_duty;
          idle_next  = bus.i_idle;
        end else begin
          cnt_next = cnt_reg - cnt_t'(1);
        end
      end
      default: begin
        state_next    = S_STOP;
        cnt_next      = '0;
        stop_req_next = 1'b0;
      end
    endcase
  end

  assign bus.o_ano_top  = out_reg.ano_top;
  assign bus.o_ano_bot  = out_reg.ano_bot;
  assign bus.o_cat_top  = out_reg.cat_top;
  assign bus.o_cat_bot  = out_reg.cat_bot;
  assign bus.o_curr_ena = out_reg.curr_ena;
  assign bus.o_led_r    = led_r_reg;
  assign bus.o_led_g    = ~led_r_reg;
  assign bus.o_led_b    = out_reg.curr_ena;
endmodule

// File: tb/tb_ci_stim_fpga_wrapper.sv
// Scoreboard bench for the stimulator: expected phase segments are queued when
// stimulus is applied and compared against measured output runs.
module tb_ci_stim_fpga_wrapper;
  logic clk = 1'b0;
  logic rst = 1'b1;

  ci_stim_fpga_wrapper_if bus ();

  ci_stim_fpga_wrapper #(
    .UNIT_CYC     (10),
    .GAP_CYC      (2),
    .IDLE_UNIT_CYC(100)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  always #150 clk = ~clk;

  typedef struct {
    logic [4:0] vec;
    int         len;
    string      tag;
  } seg_t;

  localparam logic [4:0] V_ANO = 5'b10011;
  localparam logic [4:0] V_CAT = 5'b01101;
  localparam logic [4:0] V_OFF = 5'b00000;

  seg_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  bit   mon_en = 1'b0;

  task automatic chk(string tag, int obs, int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic logic [4:0] cur_vec();
    return {bus.o_ano_top, bus.o_ano_bot, bus.o_cat_top, bus.o_cat_bot, bus.o_curr_ena};
  endfunction

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_seg(logic [4:0] vec, int len, string tag);
    seg_t s;
    s.vec = vec;
    s.len = len;
    s.tag = tag;
    exp_q.push_back(s);
  endtask

  task automatic push_pulse(int duty, int idle, bit with_ipi);
    push_seg(V_ANO, (duty + 1) * 10, "ano");
    push_seg(V_OFF, 2, "gap");
    push_seg(V_CAT, (duty + 1) * 10, "cat");
    if (with_ipi) push_seg(V_OFF, (idle + 1) * 100, "ipi");
  endtask

  // Called at the first cycle of a segment; measures each run until the outputs change.
  task automatic consume(int nseg);
    for (int i = 0; i < nseg; i++) begin
      seg_t       s;
      logic [4:0] v;
      int         n;
      if (exp_q.size() == 0) begin
        chk("queue_empty", 1, 0);
        return;
      end
      s = exp_q.pop_front();
      v = cur_vec();
      n = 0;
      while (cur_vec() == v && n < s.len + 20) begin
        tick(1);
        n++;
      end
      $display("seg %s vec=%b len=%0d (exp vec=%b len=%0d)", s.tag, v, n, s.vec, s.len);
      chk({s.tag, "_vec"}, int'(v), int'(s.vec));
      chk({s.tag, "_len"}, n, s.len);
    end
  endtask

  task automatic press_start_and_align();
    int n;
    bus.i_start_btn = 1'b1;
    n = 0;
    while (cur_vec() == V_OFF && n < 20) begin
      tick(1);
      n++;
    end
    $display("start latency %0d cycles", n);
    chk("start_lat", n, 4);
    bus.i_start_btn = 1'b0;
  endtask

  task automatic do_reset(int cyc);
    rst = 1'b1;
    tick(cyc);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic count_active(int cyc, output int cnt);
    cnt = 0;
    for (int i = 0; i < cyc; i++) begin
      tick(1);
      if (cur_vec() != V_OFF) cnt++;
    end
  endtask

  always @(negedge clk) begin
    if (mon_en)
      chk("excl", int'({bus.o_ano_top & bus.o_ano_bot,
                        bus.o_cat_top & bus.o_cat_bot,
                        bus.o_ano_top & bus.o_cat_top}), 0);
  end

  initial begin
    int cnt;
    bus.i_start_btn = 1'b0;
    bus.i_stop_btn  = 1'b0;
    bus.i_duty      = 3'd0;
    bus.i_idle      = 3'd0;

    // Reset state, and no activity while idle.
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    mon_en = 1'b1;
    chk("rst_vec", int'(cur_vec()), int'(V_OFF));
    chk("rst_led_r", int'(bus.o_led_r), 1);
    chk("rst_led_g", int'(bus.o_led_g), 0);
    chk("rst_led_b", int'(bus.o_led_b), 0);
    count_active(50, cnt);
    chk("idle_stop", cnt, 0);
    chk("idle_led_r", int'(bus.o_led_r), 1);

    // Maximum settings: 80/2/80/800, period 962.
    bus.i_duty = 3'd7;
    bus.i_idle = 3'd7;
    push_pulse(7, 7, 1'b1);
    push_pulse(7, 7, 1'b1);
    press_start_and_align();
    chk("run_led_g", int'(bus.o_led_g), 1);
    chk("run_led_b", int'(bus.o_led_b), 1);
    consume(8);
    chk("max_repeat", int'(cur_vec()), int'(V_ANO));
    do_reset(2);

    // Minimum settings, duty changed mid-anodic phase applies from next pulse.
    bus.i_duty = 3'd0;
    bus.i_idle = 3'd0;
    push_pulse(0, 0, 1'b1);
    push_pulse(3, 0, 1'b1);
    press_start_and_align();
    bus.i_duty = 3'd3;
    consume(8);
    chk("min_repeat", int'(cur_vec()), int'(V_ANO));
    do_reset(2);

    // Stop during anodic phase: pulse completes, then stopped.
    bus.i_duty = 3'd0;
    bus.i_idle = 3'd1;
    push_pulse(0, 1, 1'b0);
    press_start_and_align();
    fork
      consume(3);
      begin
        tick(1);
        bus.i_stop_btn = 1'b1;
        tick(5);
        bus.i_stop_btn = 1'b0;
      end
    join
    tick(3);
    chk("stop_led_r", int'(bus.o_led_r), 1);
    chk("stop_led_g", int'(bus.o_led_g), 0);
    count_active(300, cnt);
    chk("stop_no_pulse", cnt, 0);

    // Simultaneous start and stop while stopped.
    bus.i_start_btn = 1'b1;
    bus.i_stop_btn  = 1'b1;
    count_active(20, cnt);
    chk("both_no_pulse", cnt, 0);
    chk("both_led_r", int'(bus.o_led_r), 1);
    bus.i_start_btn = 1'b0;
    bus.i_stop_btn  = 1'b0;
    tick(5);

    // Start pressed while running has no effect on timing.
    bus.i_duty = 3'd1;
    bus.i_idle = 3'd0;
    push_pulse(1, 0, 1'b1);
    push_pulse(1, 0, 1'b1);
    press_start_and_align();
    fork
      consume(8);
      begin
        tick(4);
        bus.i_start_btn = 1'b1;
        tick(5);
        bus.i_start_btn = 1'b0;
      end
    join
    chk("restart_repeat", int'(cur_vec()), int'(V_ANO));
    do_reset(2);

    // Reset in the middle of the cathodic phase.
    bus.i_duty = 3'd2;
    bus.i_idle = 3'd0;
    push_seg(V_ANO, 30, "ano");
    push_seg(V_OFF, 2, "gap");
    press_start_and_align();
    consume(2);
    chk("cat_entry", int'(cur_vec()), int'(V_CAT));
    tick(5);
    rst = 1'b1;
    tick(1);
    chk("midrst_vec", int'(cur_vec()), int'(V_OFF));
    chk("midrst_led_r", int'(bus.o_led_r), 1);
    chk("midrst_led_g", int'(bus.o_led_g), 0);
    chk("midrst_led_b", int'(bus.o_led_b), 0);
    tick(2);
    rst = 1'b0;
    count_active(20, cnt);
    chk("post_rst_quiet", cnt, 0);
    chk("leftover_q", exp_q.size(), 0);

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000000;
    $display("FAIL timeout: got %0d expected %0d", 1, 0);
    $fatal(1, "bench time limit reached");
  end
endmodule

// File: doc/ci_stim_fpga_wrapper.md
Name: ci_stim_fpga_wrapper

Overview:
- Top-level wrapper of the cochlear-implant stimulator FPGA.
- Turns push-button start/stop and 3-bit duty/idle settings into a repeating, charge-balanced biphasic current pulse train.
- Drives four H-bridge switch controls, a current-source enable and an RGB status LED.
- Board clock is nominally 3.33 MHz (300 ns period).

Parameters:
- UNIT_CYC, 10, clock cycles per duty unit; each phase lasts (i_duty+1)*UNIT_CYC cycles.
- GAP_CYC, 2, inter-phase gap in cycles (all switches off); must be ≥1.
- IDLE_UNIT_CYC, 100, clock cycles per idle unit; the inter-pulse interval lasts (i_idle+1)*IDLE_UNIT_CYC cycles.

Ports:
- i_clk  in  1  system clock; all logic is on the rising edge.
- i_rst  in  1  synchronous reset, active-high.
- i_start_btn  in  1  asynchronous level; its rising edge starts stimulation.
- i_stop_btn  in  1  asynchronous level; its rising edge requests stop. Unconnected is treated as 0 (internal default).
- i_duty  in  3  phase-width code.
- i_idle  in  3  inter-pulse-interval code.
- o_ano_top  out  1  anode high-side switch.
- o_ano_bot  out  1  anode low-side switch.
- o_cat_top  out  1  cathode high-side switch.
- o_cat_bot  out  1  cathode low-side switch.
- o_curr_ena  out  1  current-source enable.
- o_led_r  out  1  stopped indicator.
- o_led_g  out  1  running indicator.
- o_led_b  out  1  pulse-active indicator.

Behaviour:
- Reset (synchronous, active-high): state S_STOP, all counters 0, synchronizers cleared. All switch outputs and o_curr_ena are 0; o_led_r=1, o_led_g=0, o_led_b=0.
- Buttons: each button passes through a 2-FF synchronizer, then a rising-edge detector (sync_q & ~sync_prev), which gives a one-cycle pulse.
- A start level first sampled at edge k produces start_pulse in cycle k+2. Outputs change at edge k+3.
- All outputs are registered and decoded from the next state, so there are no glitches.
- States:
  - S_STOP
  - S_ANO: ano_top=1, cat_bot=1, curr_ena=1
  - S_GAP: all switches 0, curr_ena=0
  - S_CAT: cat_top=1, ano_bot=1, curr_ena=1
  - S_IPI: all 0
- Each timed state lasts exactly its cycle count. A down-counter is loaded on entry, and the state is exited when the counter reaches 1.
- Transitions:
  - S_STOP --start_pulse & ~stop_pulse--> S_ANO
  - S_ANO --> S_GAP
  - S_GAP --> S_CAT
  - S_CAT --> S_IPI
  - S_IPI --timeout--> S_ANO
- i_duty and i_idle are latched on every entry to S_ANO, so one pulse always uses a consistent setting. Changes made mid-pulse take effect on the next pulse.
- Stop: a stop_pulse in any running state sets a stop_req flag. The current biphasic pulse always completes (charge balance).
  - If stop_req is set on entry to S_IPI, or a stop_pulse arrives while in S_IPI, the next state is S_STOP.
  - stop_req clears when S_STOP is entered.
- Simultaneous start_pulse and stop_pulse: stop wins, so the block stays in or returns toward S_STOP. Start pulses while running are ignored.
- Safety invariant: ano_top & ano_bot, cat_top & cat_bot, and ano_top & cat_top are never 1 in the same cycle. The bench asserts this.
- Phase width arithmetic: {1'b0,i_duty}+1 is 4 bits, multiplied by UNIT_CYC. Counter width is $clog2(8*max(UNIT_CYC,IDLE_UNIT_CYC)+1).
- i_duty=7 and i_idle=7 give the maximum 80-cycle phases and an 800-cycle interval. Both codes at 0 give 10-cycle phases and a 100-cycle interval.
- LEDs: o_led_r=(state==S_STOP); o_led_g=~o_led_r; o_led_b=o_curr_ena.
- Reset asserted mid-operation forces all outputs to 0 and S_STOP on the next edge.

Decomposition:
- Package ci_stim_pkg holds: the state enum (S_STOP, S_ANO, S_GAP, S_CAT, S_IPI), the default timing constants, and the output-vector typedef {ano_top, ano_bot, cat_top, cat_bot, curr_ena}.
- One sub-module, ci_btn_edge (2-FF synchronizer plus rising-edge detector), is instantiated twice. The FSM and timers stay in the wrapper.

Test Plan:
1. Reset held 3 cycles, buttons 0 -> all switches 0, curr_ena=0, led_r=1, led_g=0; stays in S_STOP indefinitely.
2. duty=7, idle=7; start rises and stays high -> 3 cycles later ano_top=cat_bot=curr_ena=1 for 80 cycles; then 2 gap cycles all 0; cat_top=ano_bot=1 for 80 cycles; 800 idle cycles; repeats with a period of 962 cycles.
3. duty=0, idle=0 -> phases of 10 cycles, interval 100, period 122. Changing duty to 3 mid-anodic-phase -> the current pulse keeps 10-cycle phases; the next pulse uses 40-cycle phases.
4. Stop pulse during S_ANO -> anodic, gap and cathodic phases still complete; next state is S_STOP, led_r=1; no further pulses.
5. Start and stop rising in the same cycle while stopped -> remains in S_STOP. A start pulse while running -> no change in timing.
6. Reset asserted mid-cathodic phase -> all outputs 0 at the next edge. A continuous assertion checks the switch exclusivity invariant throughout all scenarios.
